// File: rtl/uart_tx_fifo_drain.sv
// Purpose : drains an async-FIFO read port in the TX baud domain and sends
//           each word as a UART frame: start bit, data bits LSB first,
//           optional parity bit, stop bit. One line bit per CLK cycle.
// Ports   : CLK      TX baud clock, also the FIFO read clock
//           RST      synchronous active-low reset
//           RD_DATA  FIFO read data, valid whenever EMPTY=0
//           EMPTY    FIFO empty flag, synchronous to CLK
//           PAR_EN   1 = insert a parity bit after the data bits
//           PAR_TYP  0 = even parity, 1 = odd parity
//           R_INC    FIFO pop strobe (combinational), one cycle per word
//           TX_OUT   registered serial line, idle high
//           BUSY     registered, high while a frame is on the line
module uart_tx_fifo_drain #(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] RD_DATA,
  input  logic                  EMPTY,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic                  R_INC,
  output logic                  TX_OUT,
  output logic                  BUSY
);

  localparam int unsigned CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t                state_q;
  state_t                state_d;
  logic [CNT_W-1:0]      bit_cnt_q;
  logic [CNT_W-1:0]      bit_cnt_d;
  logic [DATA_WIDTH-1:0] shift_q;
  logic [DATA_WIDTH-1:0] shift_d;
  logic                  par_en_q;
  logic                  par_bit_q;
  logic                  load;
  logic                  last_bit;
  logic                  tx_d;
  logic                  busy_d;

  // A word is taken only between frames (IDLE) or on the stop bit, so a
  // waiting word follows the stop bit with no idle gap. Gating with RST
  // guarantees no pop is issued on a reset edge.
  assign load     = ((state_q == IDLE) || (state_q == STOP)) && !EMPTY && RST;
  assign R_INC    = load;
  assign last_bit = (bit_cnt_q == CNT_W'(DATA_WIDTH - 1));

  // State, counter and datapath registers
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
      TX_OUT    <= 1'b1;
      BUSY      <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      TX_OUT    <= tx_d;
      BUSY      <= busy_d;
      if (load) begin
        par_en_q  <= PAR_EN;
        par_bit_q <= (^RD_DATA) ^ PAR_TYP;
      end
    end
  end

  // Next state, bit counter and shift register
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    case (state_q)
      IDLE:    if (load) state_d = START;
      START:   state_d = DATA;
      DATA: begin
        if (last_bit) begin
          state_d   = par_en_q ? PARITY : STOP;
          bit_cnt_d = '0;
        end else begin
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
        end
      end
      PARITY:  state_d = STOP;
      STOP:    state_d = load ? START : IDLE;
      default: state_d = IDLE;
    endcase
    // shift_q[0] always holds the next data bit to be put on the line
    if (load) begin
      shift_d = RD_DATA;
    end else if (state_d == DATA) begin
      shift_d = shift_q >> 1;
    end
  end

  // Line value for the upcoming cycle, registered into TX_OUT/BUSY
  always_comb begin
    tx_d   = 1'b1;
    busy_d = (state_d != IDLE);
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_q[0];
      PARITY:  tx_d = par_bit_q;
      default: tx_d = 1'b1;
    endcase
  end

endmodule
